// File: rtl/serial_operand_datapath_pkg.sv
// Shared defaults and state type for the serial operand datapath.
package serial_operand_datapath_pkg;

  localparam int unsigned SOD_WIDTH  = 8;
  localparam int unsigned SOD_NREGS  = 4;
  localparam int unsigned SOD_ADDR_W = 2;
  localparam int unsigned SOD_CNT_W  = $clog2(SOD_WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sod_state_e;

endpackage

// File: rtl/serial_operand_datapath_shift_reg.sv
// WIDTH-bit register with parallel load, right shift with serial-in at the MSB, and hold.
module serial_shift_reg
  import serial_operand_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = SOD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_data_i;
    end else if (shift_i) begin
      q_q <= {serial_i, q_q[WIDTH-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_operand_datapath.sv
// Register file, accumulator and operand-B shifter feeding a bit-serial ALU LSB-first,
// with a bit counter that signals the last bit back to the control FSM.
module serial_operand_datapath
  import serial_operand_datapath_pkg::*;
#(
  parameter int unsigned WIDTH  = SOD_WIDTH,
  parameter int unsigned NREGS  = SOD_NREGS,
  parameter int unsigned ADDR_W = SOD_ADDR_W,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_start,
  input  logic              reg_shift_en,
  input  logic              acc_write_en,
  input  logic              acc_load_en,
  input  logic              reg_store_en,
  input  logic [ADDR_W-1:0] rs_sel,
  input  logic [ADDR_W-1:0] rd_sel,
  input  logic              use_imm,
  input  logic [WIDTH-1:0]  imm,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              alu_result_bit,
  output logic              op_a_bit,
  output logic              op_b_bit,
  output logic [CNT_W-1:0]  bit_idx,
  output logic              busy,
  output logic              bit_done,
  output logic [WIDTH-1:0]  acc_out
);

  sod_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] opb_d;

  logic busy_w;
  logic last_bit;
  logic shift_w;
  logic acc_load_w;
  logic acc_shift_w;
  logic store_w;

  assign busy_w   = (state_q == ST_SHIFT);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // alu_start outranks everything; a restart while busy reloads operand B but leaves the accumulator as is.
  assign shift_w     = busy_w & reg_shift_en & ~alu_start;
  assign acc_shift_w = shift_w & acc_write_en;
  assign acc_load_w  = ~busy_w & acc_load_en & ~alu_start;
  assign store_w     = ~busy_w & reg_store_en & ~alu_start;

  always_comb begin
    opb_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rs_sel == ADDR_W'(i)) begin
        opb_d = regs_q[i];
      end
    end
    if (use_imm) begin
      opb_d = imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (alu_start) begin
      state_q <= ST_SHIFT;
      cnt_q   <= '0;
    end else if (shift_w) begin
      if (last_bit) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Out-of-range rd_sel matches no entry, so the write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (store_w) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (rd_sel == ADDR_W'(i)) begin
          regs_q[i] <= acc_q;
        end
      end
    end
  end

  serial_shift_reg #(
    .WIDTH(WIDTH)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (acc_load_w),
    .shift_i    (acc_shift_w),
    .load_data_i(load_data),
    .serial_i   (alu_result_bit),
    .q_o        (acc_q)
  );

  serial_shift_reg #(
    .WIDTH(WIDTH)
  ) u_opb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (alu_start),
    .shift_i    (shift_w),
    .load_data_i(opb_d),
    .serial_i   (1'b0),
    .q_o        (opb_q)
  );

  assign busy     = busy_w;
  assign bit_idx  = cnt_q;
  assign bit_done = busy_w & reg_shift_en & last_bit;
  assign op_a_bit = busy_w & acc_q[0];
  assign op_b_bit = busy_w & opb_q[0];
  assign acc_out  = acc_q;

endmodule

// File: tb/tb_serial_operand_datapath.sv
// Randomised and directed bench for serial_operand_datapath against a behavioural serial-adder model.
module tb_serial_operand_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_start, reg_shift_en, acc_write_en, acc_load_en, reg_store_en;
  logic [1:0] rs_sel, rd_sel;
  logic       use_imm;
  logic [7:0] imm, load_data;
  logic       alu_result_bit;
  logic       op_a_bit, op_b_bit, busy, bit_done;
  logic [2:0] bit_idx;
  logic [7:0] acc_out;

  always #5 clk = ~clk;

  serial_operand_datapath #(
    .WIDTH (8),
    .NREGS (4),
    .ADDR_W(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_start     (alu_start),
    .reg_shift_en  (reg_shift_en),
    .acc_write_en  (acc_write_en),
    .acc_load_en   (acc_load_en),
    .reg_store_en  (reg_store_en),
    .rs_sel        (rs_sel),
    .rd_sel        (rd_sel),
    .use_imm       (use_imm),
    .imm           (imm),
    .load_data     (load_data),
    .alu_result_bit(alu_result_bit),
    .op_a_bit      (op_a_bit),
    .op_b_bit      (op_b_bit),
    .bit_idx       (bit_idx),
    .busy          (busy),
    .bit_done      (bit_done),
    .acc_out       (acc_out)
  );

  // Behavioural model: accumulator, operand B, register file, bit position and adder carry.
  logic [7:0] m_acc, m_opb;
  logic [7:0] m_regs [4];
  bit         m_busy, m_carry;
  int         m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_a, cap_b;
  int         cap_n, done_n, done_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_opb = '0; m_busy = 0; m_cnt = 0; m_carry = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
  endtask

  task automatic model_update();
    bit a, b, r;
    if (!rst_n) begin
      model_reset();
    end else if (alu_start) begin
      m_opb = use_imm ? imm : m_regs[rs_sel];
      m_cnt = 0; m_busy = 1; m_carry = 0;
    end else if (m_busy) begin
      if (reg_shift_en) begin
        a = m_acc[0]; b = m_opb[0];
        r = a ^ b ^ m_carry;
        m_carry = (a & b) | (a & m_carry) | (b & m_carry);
        if (acc_write_en) m_acc = (m_acc >> 1) | (8'(r) << 7);
        m_opb = m_opb >> 1;
        if (m_cnt == 7) begin m_busy = 0; m_cnt = 0; end
        else m_cnt++;
      end
    end else begin
      if (reg_store_en) m_regs[rd_sel] = m_acc;
      if (acc_load_en)  m_acc = load_data;
    end
  endtask

  task automatic compare_all();
    chk("busy",     32'(busy),     32'(m_busy));
    chk("bit_idx",  32'(bit_idx),  32'(m_cnt));
    chk("op_a_bit", 32'(op_a_bit), 32'(m_busy & m_acc[0]));
    chk("op_b_bit", 32'(op_b_bit), 32'(m_busy & m_opb[0]));
    chk("bit_done", 32'(bit_done), 32'(m_busy & reg_shift_en & (m_cnt == 7) & rst_n));
    chk("acc_out",  32'(acc_out),  32'(m_acc));
  endtask

  task automatic clr_cap();
    cap_a = '0; cap_b = '0; cap_n = 0; done_n = 0; done_idx = -1;
  endtask

  task automatic tick();
    alu_result_bit = m_busy & (m_acc[0] ^ m_opb[0] ^ m_carry);
    #1;
    compare_all();
    if (m_busy && reg_shift_en && !alu_start && rst_n) begin
      if (cap_n < 8) begin
        cap_a[cap_n] = op_a_bit;
        cap_b[cap_n] = op_b_bit;
      end
      cap_n++;
    end
    if (bit_done) begin done_n++; done_idx = int'(bit_idx); end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    alu_start = 0; reg_shift_en = 0; acc_write_en = 0; acc_load_en = 0; reg_store_en = 0;
  endtask

  task automatic start_op(input bit ui, input logic [7:0] iv, input logic [1:0] rs);
    idle_inputs();
    alu_start = 1; use_imm = ui; imm = iv; rs_sel = rs;
    reg_shift_en = 1; acc_write_en = 1;
    tick();
    idle_inputs();
    clr_cap();
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) begin
      reg_shift_en = 1; acc_write_en = 1;
      tick();
    end
    reg_shift_en = 0; acc_write_en = 0;
  endtask

  logic [7:0] frz_acc;
  logic [2:0] frz_idx;

  initial begin
    rst_n = 0; idle_inputs();
    rs_sel = 0; rd_sel = 0; use_imm = 0; imm = 0; load_data = 0; alu_result_bit = 0;
    model_reset(); clr_cap();
    #1;
    chk("reset_acc", 32'(acc_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    tick(); tick();
    rst_n = 1;
    tick();

    // ADD 0x05 + imm 0x03
    acc_load_en = 1; load_data = 8'h05; tick(); idle_inputs();
    start_op(1, 8'h03, 2'd0);
    shifts(8);
    chk("add_acc", 32'(acc_out), 32'h08);
    chk("add_opa_bits", 32'(cap_a), 32'h05);
    chk("add_opb_bits", 32'(cap_b), 32'h03);
    chk("add_done_count", 32'(done_n), 32'd1);
    chk("add_done_idx", 32'(done_idx), 32'd7);
    chk("add_busy_after", 32'(busy), 32'h0);
    tick();

    // store to reg[2], operate from it with a 3-cycle stall at bit 3
    reg_store_en = 1; rd_sel = 2'd2; tick(); idle_inputs();
    start_op(0, 8'h00, 2'd2);
    shifts(3);
    frz_acc = acc_out; frz_idx = bit_idx;
    chk("stall_idx_at", 32'(frz_idx), 32'd3);
    for (int i = 0; i < 3; i++) begin
      reg_shift_en = 0; acc_write_en = 1; tick();
    end
    chk("stall_idx_frozen", 32'(bit_idx), 32'(frz_idx));
    chk("stall_acc_frozen", 32'(acc_out), 32'(frz_acc));
    shifts(5);
    chk("reg2_opb_bits", 32'(cap_b), 32'h08);
    chk("stall_done_count", 32'(done_n), 32'd1);
    chk("stall_shift_count", 32'(cap_n), 32'd8);
    chk("reg2_acc", 32'(acc_out), 32'h10);

    // load/store while busy are ignored
    start_op(1, 8'h21, 2'd0);
    for (int i = 0; i < 8; i++) begin
      acc_load_en = 1; load_data = 8'hAA; reg_store_en = 1; rd_sel = 2'd1;
      reg_shift_en = 1; acc_write_en = 1;
      tick();
    end
    idle_inputs();
    chk("busy_ignore_acc", 32'(acc_out), 32'h31);
    start_op(0, 8'h00, 2'd1);
    shifts(8);
    chk("busy_ignore_reg1", 32'(cap_b), 32'h00);

    // simultaneous load and store: store takes pre-load value
    acc_load_en = 1; load_data = 8'h08; tick(); idle_inputs();
    acc_load_en = 1; load_data = 8'h11; reg_store_en = 1; rd_sel = 2'd1; tick(); idle_inputs();
    chk("same_cycle_acc", 32'(acc_out), 32'h11);
    start_op(0, 8'h00, 2'd1);
    shifts(8);
    chk("same_cycle_reg1", 32'(cap_b), 32'h08);

    // asynchronous reset mid-operation at bit 4
    start_op(0, 8'h00, 2'd2);
    shifts(4);
    reg_shift_en = 1; acc_write_en = 1;
    chk("pre_reset_idx", 32'(bit_idx), 32'd4);
    rst_n = 0;
    #1;
    chk("arst_acc", 32'(acc_out), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_idx", 32'(bit_idx), 32'h0);
    chk("arst_opa", 32'(op_a_bit), 32'h0);
    chk("arst_opb", 32'(op_b_bit), 32'h0);
    chk("arst_done", 32'(bit_done), 32'h0);
    model_reset();
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    start_op(0, 8'h00, 2'd2);
    shifts(8);
    chk("arst_reg2", 32'(cap_b), 32'h00);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      rs_sel = 2'($urandom_range(0, 3));
      rd_sel = 2'($urandom_range(0, 3));
      use_imm = 1'($urandom_range(0, 1));
      imm = 8'($urandom);
      load_data = 8'($urandom);
      alu_start    = !m_busy && ($urandom_range(0, 4) == 0);
      reg_shift_en = ($urandom_range(0, 3) != 0);
      acc_write_en = ($urandom_range(0, 5) != 0);
      acc_load_en  = ($urandom_range(0, 4) == 0);
      reg_store_en = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
